// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming(38,32) encoder with optional single-bit fault injection
// and a 2-entry output queue so the stream keeps one word per cycle under back-pressure.

package hamming_encoder_stream_pkg;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PAR_W   = 6;
    localparam int unsigned CODE_W  = 38;
    localparam int unsigned POS_W   = 6;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned QCNT_W  = 2;

    typedef struct packed {
        logic              injected;
        logic [CODE_W-1:0] code;
    } entry_t;
endpackage

module hamming_encoder_stream
    import hamming_encoder_stream_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [POS_W-1:0]   inj_pos,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CODE_W-1:0]  out_data,
    output logic               out_injected,
    output logic [COUNT_W-1:0] word_count
);

    // Data bits fill every non-power-of-two position in ascending order.
    function automatic logic [CODE_W-1:0] place_data(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        int unsigned       j;
        c = '0;
        j = 0;
        for (int unsigned pos = 1; pos <= CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[6'(pos - 1)] = d[5'(j)];
                j++;
            end
        end
        return c;
    endfunction

    // Parity k at position 2^k covers every data position with index bit k set.
    function automatic logic [CODE_W-1:0] add_parity(input logic [CODE_W-1:0] c_in);
        logic [CODE_W-1:0] c;
        logic              p;
        c = c_in;
        for (int unsigned k = 0; k < PAR_W; k++) begin
            p = 1'b0;
            for (int unsigned pos = 1; pos <= CODE_W; pos++) begin
                if ((((pos >> k) & 1) != 0) && ((pos & (pos - 1)) != 0)) begin
                    p = p ^ c[6'(pos - 1)];
                end
            end
            c[6'((1 << k) - 1)] = p;
        end
        return c;
    endfunction

    logic               inj_hit_c;
    logic [CODE_W-1:0]  inj_mask_c;
    entry_t             new_entry_c;
    logic               push_c;
    logic               pop_c;
    logic [QCNT_W-1:0]  count_d_c;

    logic [QCNT_W-1:0]  count_q;
    entry_t             head_q;
    entry_t             tail_q;

    always_comb begin
        inj_hit_c  = (inj_pos != '0) && (inj_pos <= POS_W'(CODE_W));
        inj_mask_c = '0;
        if (inj_hit_c) begin
            inj_mask_c = CODE_W'(1) << (inj_pos - POS_W'(1));
        end
        new_entry_c.code     = add_parity(place_data(in_data)) ^ inj_mask_c;
        new_entry_c.injected = inj_hit_c;
    end

    assign in_ready = (count_q != QCNT_W'(2)) && !rst;
    assign push_c   = in_valid && in_ready;
    assign pop_c    = out_valid && out_ready;

    always_comb begin
        count_d_c = count_q;
        if (push_c && !pop_c) begin
            count_d_c = count_q + QCNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d_c = count_q - QCNT_W'(1);
        end
    end

    // Head register drives the outputs directly; it keeps its value once emptied.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            out_valid  <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            word_count <= '0;
        end else begin
            count_q   <= count_d_c;
            out_valid <= (count_d_c != '0);

            if (push_c && ((count_q == '0) || pop_c)) begin
                head_q <= new_entry_c;
            end else if (pop_c && (count_q == QCNT_W'(2))) begin
                head_q <= tail_q;
            end

            if (push_c && !pop_c && (count_q == QCNT_W'(1))) begin
                tail_q <= new_entry_c;
            end

            if (pop_c && (word_count != '1)) begin
                word_count <= word_count + COUNT_W'(1);
            end
        end
    end

    assign out_data     = head_q.code;
    assign out_injected = head_q.injected;

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Self-checking bench for hamming_encoder_stream against a syndrome-based
// reference encoder/decoder.

module tb_hamming_encoder_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  inj_pos;
    logic        out_valid;
    logic        out_ready;
    logic [37:0] out_data;
    logic        out_injected;
    logic [15:0] word_count;

    int errors = 0;
    int checks = 0;
    int wc_exp = 0;

    always #5 clk = ~clk;

    hamming_encoder_stream dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .inj_pos      (inj_pos),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_injected (out_injected),
        .word_count   (word_count)
    );

    // Encoder: parity bits are the binary syndrome of the placed data positions.
    function automatic logic [37:0] ref_encode(input logic [31:0] d, input logic [5:0] inj);
        logic [37:0] c;
        int          syn;
        int          j;
        c   = '0;
        syn = 0;
        j   = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[6'(pos - 1)] = d[5'(j)];
                if (d[5'(j)]) syn = syn ^ pos;
                j++;
            end
        end
        for (int k = 0; k < 6; k++) c[6'((1 << k) - 1)] = syn[5'(k)];
        if (inj >= 6'd1 && inj <= 6'd38) c[inj - 6'd1] = ~c[inj - 6'd1];
        return c;
    endfunction

    task automatic ref_decode(input logic [37:0] c, output logic [31:0] d, output logic err);
        logic [37:0] cc;
        int          syn;
        int          j;
        syn = 0;
        for (int pos = 1; pos <= 38; pos++) if (c[6'(pos - 1)]) syn = syn ^ pos;
        err = (syn != 0);
        cc  = c;
        if (syn >= 1 && syn <= 38) cc[6'(syn - 1)] = ~cc[6'(syn - 1)];
        d = '0;
        j = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[5'(j)] = cc[6'(pos - 1)];
                j++;
            end
        end
    endtask

    function automatic logic [15:0] exp_wc();
        return (wc_exp > 65535) ? 16'hFFFF : 16'(wc_exp);
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; inj_pos = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 38'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (out_injected !== 1'b0) begin errors++; $display("FAIL reset_out_injected: got %b expected 0", out_injected); end
        checks++; if (word_count !== 16'h0) begin errors++; $display("FAIL reset_word_count: got %h expected 0", word_count); end
        rst = 1'b0;
        wc_exp = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_vectors();
        logic [31:0] vin [4];
        logic [37:0] vexp [4];
        vin  = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF};
        vexp = '{38'h0, 38'h7, 38'h19, 38'h3F_7FFF_FFF4};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = vin[i]; inj_pos = 6'd0;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL vec_in_ready[%0d]: got %b expected 1", i, in_ready); end
            @(posedge clk);
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL vec_out_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== vexp[i]) begin errors++; $display("FAIL vec_out_data[%0d]: got %h expected %h", i, out_data, vexp[i]); end
            checks++; if (out_injected !== 1'b0) begin errors++; $display("FAIL vec_out_injected[%0d]: got %b expected 0", i, out_injected); end
            wc_exp++;
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec_drained: got %b expected 0", out_valid); end
        checks++; if (word_count !== 16'd4) begin errors++; $display("FAIL vec_word_count: got %0d expected 4", word_count); end
    endtask

    task automatic test_inject();
        logic [31:0] d;
        logic        err;
        logic [5:0]  injs [4];
        logic [31:0] dat;
        logic [37:0] exp_code;
        injs = '{6'd3, 6'd38, 6'd39, 6'd63};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat = (i == 0) ? 32'h1 : $urandom();
            exp_code = ref_encode(dat, injs[i]);
            in_valid = 1'b1; in_data = dat; inj_pos = injs[i];
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            if (i == 0) begin
                checks++; if (out_data !== 38'h3) begin errors++; $display("FAIL inj3_out_data: got %h expected 0000000003", out_data); end
            end
            checks++; if (out_data !== exp_code) begin errors++; $display("FAIL inj_out_data[pos %0d]: got %h expected %h", injs[i], out_data, exp_code); end
            checks++; if (out_injected !== (injs[i] <= 6'd38)) begin errors++; $display("FAIL inj_flag[pos %0d]: got %b expected %b", injs[i], out_injected, injs[i] <= 6'd38); end
            ref_decode(out_data, d, err);
            checks++; if (d !== dat) begin errors++; $display("FAIL inj_decode_data[pos %0d]: got %h expected %h", injs[i], d, dat); end
            checks++; if (err !== (injs[i] <= 6'd38)) begin errors++; $display("FAIL inj_decode_err[pos %0d]: got %b expected %b", injs[i], err, injs[i] <= 6'd38); end
            @(posedge clk);
            @(negedge clk);
            wc_exp++;
        end
        checks++; if (word_count !== exp_wc()) begin errors++; $display("FAIL inj_word_count: got %0d expected %0d", word_count, exp_wc()); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] w [3];
        w = '{$urandom(), $urandom(), $urandom()};
        out_ready = 1'b0; in_valid = 1'b1; inj_pos = 6'd0; in_data = w[0];
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b expected 1", in_ready); end
        @(posedge clk); @(negedge clk);
        in_data = w[1];
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", in_ready); end
        checks++; if (out_data !== ref_encode(w[0], 6'd0)) begin errors++; $display("FAIL bp_head0: got %h expected %h", out_data, ref_encode(w[0], 6'd0)); end
        @(posedge clk); @(negedge clk);
        in_data = w[2];
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", in_ready); end
        @(posedge clk); @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full: got %b expected 0", in_ready); end
        checks++; if (out_data !== ref_encode(w[0], 6'd0)) begin errors++; $display("FAIL bp_stall_stable: got %h expected %h", out_data, ref_encode(w[0], 6'd0)); end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", in_ready); end
        checks++; if (out_data !== ref_encode(w[1], 6'd0)) begin errors++; $display("FAIL bp_head1: got %h expected %h", out_data, ref_encode(w[1], 6'd0)); end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid2: got %b expected 1", out_valid); end
        checks++; if (out_data !== ref_encode(w[2], 6'd0)) begin errors++; $display("FAIL bp_head2: got %h expected %h", out_data, ref_encode(w[2], 6'd0)); end
        @(posedge clk); @(negedge clk);
        wc_exp += 3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
        checks++; if (out_data !== ref_encode(w[2], 6'd0)) begin errors++; $display("FAIL bp_hold_last: got %h expected %h", out_data, ref_encode(w[2], 6'd0)); end
        checks++; if (word_count !== exp_wc()) begin errors++; $display("FAIL bp_word_count: got %0d expected %0d", word_count, exp_wc()); end
    endtask

    task automatic test_random();
        logic [37:0] q_code [$];
        logic        q_inj [$];
        logic [31:0] q_dat [$];
        logic [31:0] d;
        logic        err;
        logic        pend;
        logic        in_fire;
        logic        out_fire;
        int          accepted;
        int          cyc;
        accepted = 0; cyc = 0; pend = 1'b0;
        while ((accepted < 100 || q_code.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            if (!pend) begin
                in_valid = (accepted < 100) && ($urandom_range(0, 3) != 0);
                in_data  = $urandom();
                inj_pos  = 6'($urandom_range(0, 63));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                if (q_code.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rnd_extra_word: got %h expected no word", out_data);
                end else begin
                    checks++; if (out_data !== q_code[0]) begin errors++; $display("FAIL rnd_code: got %h expected %h", out_data, q_code[0]); end
                    checks++; if (out_injected !== q_inj[0]) begin errors++; $display("FAIL rnd_injected: got %b expected %b", out_injected, q_inj[0]); end
                    ref_decode(out_data, d, err);
                    checks++; if (d !== q_dat[0]) begin errors++; $display("FAIL rnd_roundtrip: got %h expected %h", d, q_dat[0]); end
                    checks++; if (err !== out_injected) begin errors++; $display("FAIL rnd_err_flag: got %b expected %b", err, out_injected); end
                    void'(q_code.pop_front()); void'(q_inj.pop_front()); void'(q_dat.pop_front());
                end
                wc_exp++;
            end
            if (in_fire) begin
                q_code.push_back(ref_encode(in_data, inj_pos));
                q_inj.push_back(inj_pos >= 6'd1 && inj_pos <= 6'd38);
                q_dat.push_back(in_data);
                accepted++;
            end
            pend = in_valid && !in_fire;
            cyc++;
        end
        checks++; if (cyc >= 3000) begin errors++; $display("FAIL rnd_timeout: got %0d cycles expected under 3000", cyc); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_drained: got %b expected 0", out_valid); end
        checks++; if (word_count !== exp_wc()) begin errors++; $display("FAIL rnd_word_count: got %0d expected %0d", word_count, exp_wc()); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0; in_valid = 1'b1; inj_pos = 6'd5; in_data = $urandom();
        @(posedge clk); @(negedge clk);
        in_data = $urandom();
        @(posedge clk); @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got %b expected 0", in_ready); end
        rst = 1'b1; out_ready = 1'b1; in_data = $urandom();
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %b expected 0", in_ready); end
        @(posedge clk); @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        wc_exp = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        checks++; if (word_count !== 16'h0) begin errors++; $display("FAIL mid_word_count: got %0d expected 0", word_count); end
        checks++; if (out_data !== 38'h0) begin errors++; $display("FAIL mid_out_data: got %h expected 0", out_data); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_output[%0d]: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_saturation();
        int sent;
        int cyc;
        sent = 0; cyc = 0;
        out_ready = 1'b1; inj_pos = 6'd0;
        while ((sent < 65537 || out_valid) && cyc < 66000) begin
            in_valid = (sent < 65537);
            in_data  = $urandom();
            #1;
            if (wc_exp >= 65533 || (wc_exp % 16384) == 0) begin
                checks++; if (word_count !== exp_wc()) begin errors++; $display("FAIL sat_word_count[%0d]: got %h expected %h", wc_exp, word_count, exp_wc()); end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) wc_exp++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (cyc >= 66000) begin errors++; $display("FAIL sat_timeout: got %0d cycles expected under 66000", cyc); end
        @(negedge clk);
        checks++; if (word_count !== 16'hFFFF) begin errors++; $display("FAIL sat_final: got %h expected ffff", word_count); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_vectors();
        test_inject();
        test_back_pressure();
        test_random();
        test_reset_midstream();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
